seg_7_scan_driver: RTL and testbench

//   Front end for the 4-digit 7-segment display path. Captures a binary value (e.g. score)
//   on a load strobe and converts it to 4 BCD digits with a sequential double-dabble FSM.

---
 rtl/seg_7_scan_driver.sv | 86 ++++++++
 tb/tb_seg_7_scan_driver.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seg_7_scan_driver.sv
// seg_7_scan_driver: binary-to-BCD front end and digit scanner for a 4-digit 7-segment display
// Ports:
//   CLK, RESET      clock and synchronous active-high reset
//   VALUE_IN        binary value, clamped to 9999 when a load is accepted
//   LOAD_IN         load strobe, honoured only while not busy
//   DOT_MASK_IN     per-digit dot enables, used live
//   BUSY_OUT        conversion in progress
//   SEG_SELECT_OUT  {2'b00, digit index}
//   BIN_OUT         BCD nibble of the selected digit
//   DOT_OUT         dot enable of the selected digit
module seg_7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BIN_WIDTH   = 14
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [BIN_WIDTH-1:0] VALUE_IN,
    input  logic                 LOAD_IN,
    input  logic [3:0]           DOT_MASK_IN,
    output logic                 BUSY_OUT,
    output logic [3:0]           SEG_SELECT_OUT,
    output logic [3:0]           BIN_OUT,
    output logic                 DOT_OUT
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [BIN_WIDTH-1:0] MAX_VAL = BIN_WIDTH'(9999);
    localparam logic [3:0] LAST = 4'(BIN_WIDTH - 1);
    localparam logic [PW-1:0] PRESC_TOP = PW'(REFRESH_DIV - 1);
    typedef enum logic {IDLE, CONV} state_t;
    state_t               state;
    logic [BIN_WIDTH-1:0] bin_sr;
    logic [15:0]          bcd;
    logic [15:0]          bcd_adj;
    logic [15:0]          bcd_next;
    logic [15:0]          disp;
    logic [3:0]           cnt;
    logic [PW-1:0]        presc;
    logic [1:0]           index;
    // double-dabble step: correct nibbles >=5 so the following shift carries into the next digit
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++)
            bcd_adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
        bcd_next = {bcd_adj[14:0], bin_sr[BIN_WIDTH-1]};
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            bin_sr <= '0;
            bcd    <= '0;
            cnt    <= '0;
            disp   <= '0;
        end else if (state == IDLE) begin
            if (LOAD_IN) begin
                state  <= CONV;
                bin_sr <= (VALUE_IN > MAX_VAL) ? MAX_VAL : VALUE_IN;
                bcd    <= '0;
                cnt    <= '0;
            end
        end else begin
            bcd    <= bcd_next;
            bin_sr <= bin_sr << 1;
            cnt    <= cnt + 4'd1;
            // only the finished result reaches the display register
            if (cnt == LAST) begin
                disp  <= bcd_next;
                state <= IDLE;
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            presc <= '0;
            index <= '0;
        end else if (presc == PRESC_TOP) begin
            presc <= '0;
            index <= index + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end
    assign BUSY_OUT       = (state == CONV);
    assign SEG_SELECT_OUT = {2'b00, index};
    assign BIN_OUT        = disp[index*4 +: 4];
    assign DOT_OUT        = DOT_MASK_IN[index];
endmodule

// File: tb/tb_seg_7_scan_driver.sv
// tb_seg_7_scan_driver: self-checking bench for seg_7_scan_driver
module tb_seg_7_scan_driver;
    localparam int DIV = 4;
    typedef struct {
        int value;
        int d3, d2, d1, d0;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [13:0] value = '0;
    logic [3:0]  mask = '0;
    logic        busy;
    logic [3:0]  seg;
    logic [3:0]  bin;
    logic        dot;
    int n_checks = 0;
    int n_fail = 0;
    int m_rem = 0;
    int m_pend = 0;
    int m_val = 0;
    int m_n = 0;
    vec_t vecs[7];

    always #5 clk = ~clk;

    seg_7_scan_driver #(.REFRESH_DIV(DIV), .BIN_WIDTH(14)) dut (
        .CLK(clk), .RESET(rst), .VALUE_IN(value), .LOAD_IN(load), .DOT_MASK_IN(mask),
        .BUSY_OUT(busy), .SEG_SELECT_OUT(seg), .BIN_OUT(bin), .DOT_OUT(dot)
    );

    function automatic int clampv(int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic int digit(int v, int i);
        int p = 1;
        for (int j = 0; j < i; j++) p = p * 10;
        return (v / p) % 10;
    endfunction

    // reference: a load accepted while idle shows its decimal value 14 edges later
    always @(posedge clk) begin
        if (rst) begin
            m_rem <= 0;
            m_val <= 0;
            m_n   <= 0;
        end else begin
            m_n <= m_n + 1;
            if (m_rem > 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) m_val <= m_pend;
            end else if (load) begin
                m_rem  <= 14;
                m_pend <= clampv(int'(value));
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int idx;
        idx = (m_n / DIV) % 4;
        chk("busy", int'(busy), (m_rem > 0) ? 1 : 0);
        chk("seg", int'(seg), idx);
        chk("bin", int'(bin), digit(m_val, idx));
        chk("dot", int'(dot), int'(mask[idx]));
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
    endtask

    task automatic load_and_wait(input int v);
        value = 14'(v);
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (14) tick();
    endtask

    task automatic check_disp(input string name, input int d3, input int d2, input int d1, input int d0);
        int e[4];
        e[0] = d0; e[1] = d1; e[2] = d2; e[3] = d3;
        for (int i = 0; i < 4 * DIV; i++) begin
            tick();
            chk(name, int'(bin), e[seg[1:0]]);
        end
    endtask

    initial begin
        int hi;
        int v;
        vecs[0] = '{1234, 1, 2, 3, 4};
        vecs[1] = '{16383, 9, 9, 9, 9};
        vecs[2] = '{0, 0, 0, 0, 0};
        vecs[3] = '{9999, 9, 9, 9, 9};
        vecs[4] = '{1000, 1, 0, 0, 0};
        vecs[5] = '{10000, 9, 9, 9, 9};
        vecs[6] = '{8765, 8, 7, 6, 5};
        // reset held for two edges
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_seg", int'(seg), 0);
        chk("rst_bin", int'(bin), 0);
        chk("rst_dot", int'(dot), 0);
        check_all();
        // conversion latency: busy visible after edges k..k+13
        value = 14'd1234;
        load = 1'b1;
        tick();
        load = 1'b0;
        hi = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            hi++;
            tick();
        end
        chk("busy_len", hi, 14);
        check_disp("conv_1234", 1, 2, 3, 4);
        // table of values incl. clamp and extremes
        foreach (vecs[i]) begin
            load_and_wait(vecs[i].value);
            chk("vec_idle", int'(busy), 0);
            check_disp($sformatf("vec_%0d", vecs[i].value), vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0);
        end
        // scan sequence from reset with dot on digit 2
        rst = 1'b1;
        mask = 4'b0100;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("scan_seg", int'(seg), (i / 4) % 4);
            chk("scan_dot", int'(dot), ((i / 4) % 4 == 2) ? 1 : 0);
            chk("scan_bin", int'(bin), 0);
        end
        mask = 4'b0000;
        // load during busy is dropped; load right after completion is taken
        value = 14'd42;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        value = 14'd777;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (9) tick();
        chk("rej_idle", int'(busy), 0);
        check_disp("rej_42", 0, 0, 4, 2);
        load_and_wait(777);
        check_disp("acc_777", 0, 7, 7, 7);
        // reset mid-conversion discards the result
        value = 14'd5678;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        repeat (20) tick();
        check_disp("midrst_disp", 0, 0, 0, 0);
        // random loads of known values
        for (int i = 0; i < 10; i++) begin
            v = (i == 0) ? 9999 : int'($urandom_range(0, 16383));
            load_and_wait(v);
            check_disp("rand_conv", digit(clampv(v), 3), digit(clampv(v), 2), digit(clampv(v), 1), digit(clampv(v), 0));
        end
        // random strobes, held loads and live dot masks against the reference
        for (int i = 0; i < 400; i++) begin
            load = ($urandom_range(0, 3) == 0) || (i >= 100 && i < 140);
            value = 14'($urandom_range(0, 16383));
            mask = 4'($urandom);
            tick();
        end
        load = 1'b0;
        repeat (40) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
